// File: rtl/ttt_sweep_scheduler.sv
// ttt_sweep_scheduler
// Drives the shared tick-tock-token neuron datapath across a bank of
// time-multiplexed neurons. A sweep issues one TICK command per active neuron,
// then one TOCK command per active neuron. Addresses that fire on a TOCK are
// queued in a small first-word-fall-through spike FIFO for the output encoder.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   ena                 design enable; low stalls issue of new commands
//   start, num_active   sweep request and neuron count (sampled on accept)
//   busy, done, overrun sweep status; done/overrun are one-cycle pulses
//   dp_valid/dp_ready   command handshake to the datapath
//   dp_addr, dp_phase   command payload (phase 0 = TICK, 1 = TOCK)
//   dp_spike            fire flag, sampled on an accepted TOCK
//   spk_valid/spk_ready spike FIFO head handshake
//   spk_addr            spike FIFO head entry
module ttt_sweep_scheduler #(
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic [ADDR_W:0]   num_active,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic              dp_valid,
  input  logic              dp_ready,
  output logic [ADDR_W-1:0] dp_addr,
  output logic              dp_phase,
  input  logic              dp_spike,
  output logic              spk_valid,
  output logic [ADDR_W-1:0] spk_addr,
  input  logic              spk_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, TICK, TOCK, FIN} state_e;

  state_e                               state_q, state_d;
  logic [ADDR_W:0]                      n_q, n_d;
  logic [ADDR_W:0]                      addr_q, addr_d;
  logic                                 pend_q, pend_d;
  logic                                 overrun_q, overrun_d;
  logic [FIFO_DEPTH-1:0][ADDR_W-1:0]    mem_q, mem_d;
  logic [PTR_W-1:0]                     wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W:0]                       cnt_q, cnt_d;

  logic xfer, last, push, pop, fifo_room;

  assign fifo_room = (cnt_q < DEPTH_C);
  // addr is one bit wider than dp_addr so N = 2^ADDR_W compares cleanly.
  assign last      = (addr_q == (n_q - (ADDR_W+1)'(1)));

  // Command issue. pend_q remembers an offered-but-not-taken command so that
  // ena dropping or the FIFO filling can never retract it.
  always_comb begin
    dp_valid = 1'b0;
    unique case (state_q)
      TICK:    dp_valid = pend_q | ena;
      TOCK:    dp_valid = pend_q | (ena & fifo_room);
      default: dp_valid = 1'b0;
    endcase
  end

  assign xfer     = dp_valid & dp_ready;
  assign dp_addr  = addr_q[ADDR_W-1:0];
  assign dp_phase = (state_q == TOCK);
  assign busy     = (state_q == TICK) || (state_q == TOCK);
  assign done     = (state_q == FIN);
  assign overrun  = overrun_q;

  // Sweep sequencer.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    addr_d    = addr_q;
    pend_d    = dp_valid & ~dp_ready;
    overrun_d = start & (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = num_active;
          addr_d  = '0;
          state_d = (num_active == '0) ? FIN : TICK;
        end
      end
      TICK: begin
        if (xfer) begin
          if (last) begin
            addr_d  = '0;
            state_d = TOCK;
          end else begin
            addr_d = addr_q + (ADDR_W+1)'(1);
          end
        end
      end
      TOCK: begin
        if (xfer) begin
          if (last) begin
            addr_d  = '0;
            state_d = FIN;
          end else begin
            addr_d = addr_q + (ADDR_W+1)'(1);
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Spike FIFO. Full-push cannot happen: TOCK issue is gated on fifo_room.
  assign push      = xfer & (state_q == TOCK) & dp_spike;
  assign spk_valid = (cnt_q != '0);
  assign pop       = spk_valid & spk_ready;
  assign spk_addr  = mem_q[rd_q];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = dp_addr;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (pop) rd_d = rd_q + PTR_W'(1);
    if (push && !pop)      cnt_d = cnt_q + (PTR_W+1)'(1);
    else if (!push && pop) cnt_d = cnt_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      n_q       <= '0;
      addr_q    <= '0;
      pend_q    <= 1'b0;
      overrun_q <= 1'b0;
      mem_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      addr_q    <= addr_d;
      pend_q    <= pend_d;
      overrun_q <= overrun_d;
      mem_q     <= mem_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ttt_sweep_scheduler.sv
module tb_ttt_sweep_scheduler;
  localparam int ADDR_W = 4, FIFO_DEPTH = 4;

  logic clk = 0, rst_n = 0, ena = 0, start = 0;
  logic dp_ready = 0, dp_spike = 0, spk_ready = 0;
  logic [ADDR_W:0] num_active = '0;
  logic busy, done, overrun, dp_valid, dp_phase, spk_valid;
  logic [ADDR_W-1:0] dp_addr, spk_addr;

  int checks = 0, failures = 0;
  int xfer_cnt = 0, done_cnt = 0, ovr_cnt = 0;
  logic [ADDR_W:0]   exp_q[$];
  logic [ADDR_W-1:0] spk_q[$];
  logic [ADDR_W:0]   e, prev_cmd = '0;
  logic [ADDR_W-1:0] s;
  logic              prev_pend = 0;

  ttt_sweep_scheduler #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .num_active(num_active),
    .busy(busy), .done(done), .overrun(overrun),
    .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_addr(dp_addr), .dp_phase(dp_phase),
    .dp_spike(dp_spike), .spk_valid(spk_valid), .spk_addr(spk_addr), .spk_ready(spk_ready)
  );

  always #5 clk = ~clk;

  // Monitor: inputs change at posedge+1, so values seen here are what the
  // next posedge acts on.
  always @(negedge clk) begin
    if (!rst_n) prev_pend = 1'b0;
    else begin
      if (prev_pend) begin
        checks++;
        if (dp_valid !== 1'b1 || {dp_phase, dp_addr} !== prev_cmd) begin
          failures++;
          $display("FAIL hold: valid=%b cmd=%h required held cmd=%h", dp_valid, {dp_phase, dp_addr}, prev_cmd);
        end
      end
      if (dp_valid === 1'b1 && dp_ready) begin
        xfer_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_xfer: cmd=%h required none", {dp_phase, dp_addr});
        end else begin
          e = exp_q.pop_front();
          if ({dp_phase, dp_addr} !== e) begin
            failures++;
            $display("FAIL xfer_order: cmd=%h required %h", {dp_phase, dp_addr}, e);
          end
          if (e[ADDR_W] && dp_spike) spk_q.push_back(e[ADDR_W-1:0]);
        end
      end
      if (spk_valid === 1'b1 && spk_ready) begin
        checks++;
        if (spk_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_spike: spk_addr=%0d required none", spk_addr);
        end else begin
          s = spk_q.pop_front();
          if (spk_addr !== s) begin
            failures++;
            $display("FAIL spike_order: spk_addr=%0d required %0d", spk_addr, s);
          end
        end
      end
      if (done === 1'b1) done_cnt++;
      if (overrun === 1'b1) ovr_cnt++;
      prev_pend = (dp_valid === 1'b1) && !dp_ready;
      prev_cmd  = {dp_phase, dp_addr};
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic kick(input int n);
    logic [ADDR_W:0] t;
    step();
    start = 1; num_active = n[ADDR_W:0];
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < n; a++) begin
        t = {p[0], a[ADDR_W-1:0]};
        exp_q.push_back(t);
      end
    step();
    start = 0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0, k;
    d0 = done_cnt; k = 0;
    while (done_cnt == d0 && k < budget) begin @(negedge clk); k++; end
    checks++;
    if (done_cnt == d0) begin
      failures++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, overrun, dp_valid, dp_phase, spk_valid, dp_addr, spk_addr} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %b required 0",
               {busy, done, overrun, dp_valid, dp_phase, spk_valid, dp_addr, spk_addr});
    end
    step(); rst_n = 1;
  endtask

  task automatic test_basic();
    int x0, busy_n, done_k, first_k, last_k;
    ena = 1; dp_ready = 1; spk_ready = 1; dp_spike = 0;
    x0 = xfer_cnt; busy_n = 0; done_k = 0; first_k = 0; last_k = 0;
    kick(3);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1 && done_k == 0) done_k = k;
      if (dp_valid === 1'b1) begin
        if (first_k == 0) first_k = k;
        last_k = k;
      end
    end
    checks++; if (first_k != 1) begin failures++; $display("FAIL basic_first_valid: cycle %0d required 1", first_k); end
    checks++; if (last_k != 6) begin failures++; $display("FAIL basic_last_valid: cycle %0d required 6", last_k); end
    checks++; if (busy_n != 6) begin failures++; $display("FAIL basic_busy_len: %0d required 6", busy_n); end
    checks++; if (done_k != 7) begin failures++; $display("FAIL basic_done_cycle: %0d required 7", done_k); end
    checks++; if (xfer_cnt - x0 != 6) begin failures++; $display("FAIL basic_xfers: %0d required 6", xfer_cnt - x0); end
  endtask

  task automatic test_zero();
    int done_k, busy_seen, valid_seen;
    done_k = 0; busy_seen = 0; valid_seen = 0;
    kick(0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (done === 1'b1 && done_k == 0) done_k = k;
      if (busy === 1'b1) busy_seen++;
      if (dp_valid === 1'b1) valid_seen++;
    end
    checks++; if (done_k != 1) begin failures++; $display("FAIL zero_done: cycle %0d required 1", done_k); end
    checks++; if (busy_seen != 0) begin failures++; $display("FAIL zero_busy: %0d required 0", busy_seen); end
    checks++; if (valid_seen != 0) begin failures++; $display("FAIL zero_valid: %0d required 0", valid_seen); end
  endtask

  task automatic test_fifo_full();
    int x0, k;
    ena = 1; dp_ready = 1; dp_spike = 1; spk_ready = 0;
    x0 = xfer_cnt; k = 0;
    kick(8);
    while (xfer_cnt - x0 < 12 && k < 60) begin @(negedge clk); k++; end
    repeat (6) @(negedge clk);
    checks++; if (xfer_cnt - x0 != 12) begin failures++; $display("FAIL full_xfers: %0d required 12", xfer_cnt - x0); end
    checks++; if (dp_valid !== 1'b0) begin failures++; $display("FAIL full_gate: dp_valid=%b required 0", dp_valid); end
    checks++; if (spk_valid !== 1'b1 || spk_addr !== 0) begin
      failures++; $display("FAIL full_head: valid=%b addr=%0d required 1/0", spk_valid, spk_addr);
    end
    step(); spk_ready = 1;
    wait_done(100, "full");
    checks++; if (xfer_cnt - x0 != 16) begin failures++; $display("FAIL full_total: %0d required 16", xfer_cnt - x0); end
    step(); dp_spike = 0;
    repeat (6) @(negedge clk);
    checks++; if (spk_valid !== 1'b0 || spk_q.size() != 0) begin
      failures++; $display("FAIL full_drain: valid=%b left=%0d required 0/0", spk_valid, spk_q.size());
    end
  endtask

  task automatic test_stall();
    int x0, d0, k;
    ena = 1; dp_ready = 0; spk_ready = 1; dp_spike = 0;
    x0 = xfer_cnt; d0 = done_cnt; k = 0;
    kick(16);
    while (done_cnt == d0 && k < 600) begin
      step();
      dp_ready = 1'($urandom_range(0, 1));
      dp_spike = 1'($urandom_range(0, 1));
      ena = !(k >= 3 && k < 8);
      k++;
    end
    checks++; if (done_cnt == d0) begin failures++; $display("FAIL stall_timeout: no done in %0d cycles", k); end
    checks++; if (xfer_cnt - x0 != 32) begin failures++; $display("FAIL stall_xfers: %0d required 32", xfer_cnt - x0); end
    ena = 1; dp_ready = 1; dp_spike = 0;
    repeat (8) @(negedge clk);
    checks++; if (exp_q.size() != 0 || spk_q.size() != 0) begin
      failures++; $display("FAIL stall_leftover: cmds=%0d spikes=%0d required 0/0", exp_q.size(), spk_q.size());
    end
  endtask

  task automatic test_overrun();
    int x0, d0, o0;
    ena = 1; dp_ready = 1; spk_ready = 1; dp_spike = 0;
    x0 = xfer_cnt; d0 = done_cnt; o0 = ovr_cnt;
    kick(4);
    step(); step();
    start = 1; num_active = 9;
    step();
    start = 0;
    wait_done(50, "overrun");
    repeat (4) @(negedge clk);
    checks++; if (ovr_cnt - o0 != 1) begin failures++; $display("FAIL overrun_pulses: %0d required 1", ovr_cnt - o0); end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL overrun_dones: %0d required 1", done_cnt - d0); end
    checks++; if (xfer_cnt - x0 != 8) begin failures++; $display("FAIL overrun_xfers: %0d required 8", xfer_cnt - x0); end
  endtask

  task automatic test_reset_mid();
    int x0, k;
    ena = 1; dp_ready = 1; dp_spike = 1; spk_ready = 0;
    x0 = xfer_cnt; k = 0;
    kick(8);
    while (xfer_cnt - x0 < 10 && k < 40) begin @(negedge clk); k++; end
    step();
    checks++; if (spk_valid !== 1'b1 || dp_phase !== 1'b1) begin
      failures++; $display("FAIL midreset_pre: spk_valid=%b phase=%b required 1/1", spk_valid, dp_phase);
    end
    rst_n = 0;
    #1;
    checks++;
    if ({busy, done, overrun, dp_valid, dp_phase, spk_valid, dp_addr, spk_addr} !== '0) begin
      failures++;
      $display("FAIL midreset_async: got %b required 0",
               {busy, done, overrun, dp_valid, dp_phase, spk_valid, dp_addr, spk_addr});
    end
    exp_q.delete(); spk_q.delete();
    repeat (2) @(negedge clk);
    step(); rst_n = 1; dp_spike = 0; spk_ready = 1;
    x0 = xfer_cnt;
    kick(2);
    wait_done(20, "midreset");
    checks++; if (xfer_cnt - x0 != 4) begin failures++; $display("FAIL midreset_xfers: %0d required 4", xfer_cnt - x0); end
    checks++; if (spk_valid !== 1'b0) begin failures++; $display("FAIL midreset_fifo: spk_valid=%b required 0", spk_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_fifo_full();
    test_stall();
    test_overrun();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL final_cmds: %0d left required 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
